// File: rtl/conv_encoder_k7.sv
// Rate-1/2, K=7 convolutional encoder with optional zero-tail termination.
// One registered output pair; the shift register advances only when the pair is consumed.
module conv_encoder_k7 #(
  parameter int           K       = 7,
  parameter logic [K-1:0] G0      = 7'o171,
  parameter logic [K-1:0] G1      = 7'o133,
  parameter bit           TAIL_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic       i_in_bit,
  input  logic       i_in_last,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [1:0] o_out_pair,
  output logic       o_out_last
);
  localparam int TW = $clog2(K);

  typedef enum logic {S_DATA, S_TAIL} state_t;

  state_t          r_state, w_state_nxt;
  logic [K-2:0]    r_sr, w_sr_nxt;
  logic [TW-1:0]   r_tail_cnt, w_tail_nxt;
  logic            r_out_valid, w_valid_nxt;
  logic            r_out_last, w_last_nxt;
  logic [1:0]      r_out_pair, w_pair_nxt;
  logic            w_adv, w_load_data, w_u;
  logic [K-1:0]    w_win;
  logic [1:0]      w_enc;

  assign w_adv       = !r_out_valid || i_out_ready;
  assign o_in_ready  = (r_state == S_DATA) && w_adv && !i_rst;
  assign w_load_data = i_in_valid && o_in_ready;
  assign w_u         = (r_state == S_DATA) ? i_in_bit : 1'b0;

  // Window MSB is the current bit, LSB the oldest delay tap
  always_comb begin
    w_win      = '0;
    w_win[K-1] = w_u;
    for (int i = 0; i < K-1; i++) w_win[K-2-i] = r_sr[i];
  end

  assign w_enc = {^(w_win & G0), ^(w_win & G1)};

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_tail_nxt  = r_tail_cnt;
    w_valid_nxt = r_out_valid;
    w_pair_nxt  = r_out_pair;
    w_last_nxt  = r_out_last;
    if (w_adv) w_valid_nxt = 1'b0;
    case (r_state)
      S_DATA: begin
        if (w_load_data) begin
          w_valid_nxt = 1'b1;
          w_pair_nxt  = w_enc;
          w_last_nxt  = 1'b0;
          w_sr_nxt    = {r_sr[K-3:0], w_u};
          if (i_in_last) begin
            if (TAIL_EN) begin
              w_tail_nxt  = '0;
              w_state_nxt = S_TAIL;
            end else begin
              // Untailed frames are independent: start the next one from state 0
              w_last_nxt = 1'b1;
              w_sr_nxt   = '0;
            end
          end
        end
      end
      S_TAIL: begin
        if (w_adv) begin
          w_valid_nxt = 1'b1;
          w_pair_nxt  = w_enc;
          w_last_nxt  = 1'b0;
          w_sr_nxt    = {r_sr[K-3:0], 1'b0};
          w_tail_nxt  = r_tail_cnt + 1'b1;
          if (r_tail_cnt == TW'(K-2)) begin
            w_last_nxt  = 1'b1;
            w_state_nxt = S_DATA;
          end
        end
      end
      default: w_state_nxt = S_DATA;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_DATA;
      r_sr        <= '0;
      r_tail_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_pair  <= 2'b00;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_sr_nxt;
      r_tail_cnt  <= w_tail_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_pair  <= w_pair_nxt;
      r_out_last  <= w_last_nxt;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_pair  = r_out_pair;
  assign o_out_last  = r_out_last;
endmodule

// File: tb/tb_conv_encoder_k7.sv
// Scoreboard bench for conv_encoder_k7: a tap-by-tap reference encoder queues
// expected {last,pair} on every accepted bit; the monitor pops on each output handshake.
module tb_conv_encoder_k7;
  localparam int         K  = 7;
  localparam logic [6:0] G0 = 7'o171;
  localparam logic [6:0] G1 = 7'o133;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_bit, in_last, out_ready;
  logic       in_ready, out_valid, out_last;
  logic [1:0] out_pair;
  logic       z_in_valid, z_in_bit, z_in_last, z_out_ready;
  logic       z_in_ready, z_out_valid, z_out_last;
  logic [1:0] z_out_pair;

  conv_encoder_k7 #(.TAIL_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_bit(in_bit), .i_in_last(in_last), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_pair(out_pair), .o_out_last(out_last));

  conv_encoder_k7 #(.TAIL_EN(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(z_in_valid), .o_in_ready(z_in_ready),
    .i_in_bit(z_in_bit), .i_in_last(z_in_last), .o_out_valid(z_out_valid),
    .i_out_ready(z_out_ready), .o_out_pair(z_out_pair), .o_out_last(z_out_last));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: mh[j] is the input bit j steps ago
  logic [6:0] mh = '0;
  logic [2:0] sbq[$];
  logic [2:0] got_q[$];
  int         got_cyc[$];
  int         cyc = 0;
  bit         tail_flag = 0;
  bit         prev_stall = 0;
  logic [2:0] prev_out = '0;

  function automatic logic [1:0] mstep(input logic u);
    logic p0, p1;
    p0 = 1'b0;
    p1 = 1'b0;
    mh = {mh[5:0], u};
    for (int j = 0; j < K; j++) begin
      if (G0[K-1-j]) p0 ^= mh[j];
      if (G1[K-1-j]) p1 ^= mh[j];
    end
    return {p0, p1};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (prev_stall) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold", {29'd0, out_last, out_pair}, {29'd0, prev_out});
    end
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_pair});
      got_cyc.push_back(cyc);
      if (sbq.size() == 0) chk("sb_unexpected_out", {29'd0, out_last, out_pair}, 32'hffff);
      else chk("sb_pair", {29'd0, out_last, out_pair}, {29'd0, sbq.pop_front()});
    end
    if (out_valid && !out_ready) chk("stall_inrdy", {31'd0, in_ready}, 32'd0);
    if (tail_flag && !(out_valid && out_last)) chk("tail_inrdy", {31'd0, in_ready}, 32'd0);
    if (tail_flag && out_valid && out_ready && out_last) tail_flag = 0;
    if (rst) begin
      chk("rst_inrdy", {31'd0, in_ready}, 32'd0);
      sbq.delete();
      mh = '0;
      tail_flag = 0;
      prev_stall = 0;
    end else begin
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_pair};
      if (in_valid && in_ready) begin
        sbq.push_back({1'b0, mstep(in_bit)});
        if (in_last) begin
          for (int j = 1; j < K; j++) sbq.push_back({(j == K-1), mstep(1'b0)});
          tail_flag = 1;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_bit = b; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 500) begin n++; @(negedge clk); end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #2;
    while ((sbq.size() != 0 || out_valid) && n < 500) begin n++; @(posedge clk); #2; end
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic clr();
    got_q.delete();
    got_cyc.delete();
  endtask

  logic [1:0] imp  [7] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
  logic [1:0] ones [7] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11};

  task automatic chk_impulse(input string tag, input int base);
    for (int i = 0; i < 7; i++) begin
      if (base + i < got_q.size()) begin
        chk({tag, "_pair"}, {30'd0, got_q[base+i][1:0]}, {30'd0, imp[i]});
        chk({tag, "_last"}, {31'd0, got_q[base+i][2]}, {31'd0, (i == 6)});
      end else chk({tag, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  bit done;
  initial begin
    rst = 1'b1; in_valid = 0; in_bit = 0; in_last = 0; out_ready = 1'b1;
    z_in_valid = 0; z_in_bit = 0; z_in_last = 0; z_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pair", {30'd0, out_pair}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_z_valid", {31'd0, z_out_valid}, 32'd0);
    chk("rst_z_inrdy", {31'd0, z_in_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Impulse
    clr(); send_bit(1'b1, 1'b1); drain();
    chk("imp_cnt", got_q.size(), 32'd7);
    chk_impulse("imp", 0);
    if (got_cyc.size() == 7) chk("imp_contig", got_cyc[6] - got_cyc[0], 32'd6);

    // All-ones frame then an impulse frame proves the tail cleared sr
    clr();
    for (int i = 0; i < 8; i++) send_bit(1'b1, i == 7);
    send_bit(1'b1, 1'b1);
    drain();
    chk("ones_cnt", got_q.size(), 32'd21);
    for (int i = 0; i < 7; i++)
      if (i < got_q.size()) chk("ones_pair", {30'd0, got_q[i][1:0]}, {30'd0, ones[i]});
    if (got_q.size() > 13) chk("ones_last14", {31'd0, got_q[13][2]}, 32'd1);
    chk_impulse("ones_imp", 14);

    // Backpressure mid-data and mid-tail
    clr();
    fork
      for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), i == 9);
      begin
        repeat (3) @(posedge clk); #1 out_ready = 1'b0;
        repeat (5) @(posedge clk); #1 out_ready = 1'b1;
        repeat (10) @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_cnt", got_q.size(), 32'd16);

    // Back-to-back frames 101 and 11
    clr();
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
    drain();
    chk("b2b_cnt", got_q.size(), 32'd17);
    if (got_q.size() == 17) begin
      chk("b2b_lastA", {31'd0, got_q[8][2]}, 32'd1);
      chk("b2b_lastB", {31'd0, got_q[16][2]}, 32'd1);
      chk("b2b_firstB", {30'd0, got_q[9][1:0]}, 32'd3);
      chk("b2b_nogap", got_cyc[16] - got_cyc[0], 32'd16);
    end

    // Reset during the third tail pair
    clr();
    send_bit(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_drop", {31'd0, out_valid}, 32'd0);
    drain();
    clr(); send_bit(1'b1, 1'b1); drain();
    chk("post_rst_cnt", got_q.size(), 32'd7);
    chk_impulse("post_rst", 0);

    // Random frames under random backpressure
    done = 0;
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          int len;
          len = $urandom_range(1, 12);
          for (int i = 0; i < len; i++) send_bit(1'($urandom_range(0, 1)), i == len - 1);
        end
        done = 1;
      end
      begin
        while (!done) begin @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0); end
        out_ready = 1'b1;
      end
    join
    drain();

    // Untailed variant: two single-bit frames
    @(posedge clk); #1;
    z_in_valid = 1'b1; z_in_bit = 1'b1; z_in_last = 1'b1;
    @(negedge clk);
    chk("z_inrdy0", {31'd0, z_in_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("z_out1", {29'd0, z_out_valid, z_out_last, z_out_pair}, 32'b1111);
    chk("z_inrdy1", {31'd0, z_in_ready}, 32'd1);
    @(posedge clk); #1 z_in_valid = 1'b0;
    @(negedge clk);
    chk("z_out2", {29'd0, z_out_valid, z_out_last, z_out_pair}, 32'b1111);
    chk("z_inrdy2", {31'd0, z_in_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("z_idle", {31'd0, z_out_valid}, 32'd0);

    chk("sb_leftover", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_encoder_k7.md
Name: conv_encoder_k7

Overview:
- Rate-1/2, constraint-length-7 convolutional encoder. It is the transmit-side counterpart of the 64-state Viterbi decoder (BMC/ACS/traceback).
- Converts a framed serial bit stream into coded 2-bit pairs, using the same pair bit ordering the decoder's branch-metric units consume on rx_pair[1:0].
- Optionally appends K-1 zero tail bits per frame so the trellis terminates in state 0.
- Used in the decoder testbench as the reference stimulus source, and in loopback builds.

Parameters:
- K, 7, constraint length; the shift register holds K-1 = 6 bits.
- G0, 7'o171, generator for out_pair[1]; bit K-1 is the tap on the current input, bit 0 is the tap on delay K-1.
- G1, 7'o133, generator for out_pair[0]; same tap convention as G0.
- TAIL_EN, 1, 1 = append K-1 zero tail bits after in_last; 0 = truncated frames.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_bit/in_last valid
- in_ready  output  1  encoder accepts input this cycle
- in_bit  input  1  information bit
- in_last  input  1  final information bit of the frame
- out_valid  output  1  out_pair/out_last valid
- out_ready  input  1  sink accepts the output pair
- out_pair  output  2  coded pair: [1] = G0 parity, [0] = G1 parity
- out_last  output  1  final coded pair of the frame (last tail pair if TAIL_EN=1)

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high.
- Reset values: out_valid=0, out_pair=2'b00, out_last=0, sr=0, tail_cnt=0, state=DATA.
- in_ready is 0 while rst=1.
- Encoding:
  - Window w = {u, sr[0], sr[1], ..., sr[K-2]}, where sr[0] holds the most recent previous bit.
  - out_pair[1] = XOR(w & G0); out_pair[0] = XOR(w & G1).
  - On each advance: sr <= {sr[K-3:0], u}, where u is the current input bit.
- Output stage: a single registered pair.
  - Define adv = !out_valid || out_ready.
  - in_ready = (state==DATA) && adv && !rst (combinational).
  - Input handshake: in_valid && in_ready. The encoded pair is registered, and out_valid=1 from the next cycle. Latency is 1 cycle.
  - When adv=1 and nothing new is loaded, out_valid <= 0.
  - While out_valid=1 && out_ready=0: out_pair, out_last and out_valid hold stable, and sr does not advance.
  - With out_ready held at 1, throughput is 1 pair per cycle.
- State machine:
  - DATA:
    - On handshake with in_last=0: encode and stay in DATA.
    - On handshake with in_last=1 and TAIL_EN=1: encode with out_last=0, tail_cnt <= 0, go to TAIL.
    - On handshake with in_last=1 and TAIL_EN=0: encode with out_last=1, then sr <= 0 (frames are independent), stay in DATA.
  - TAIL:
    - in_ready=0.
    - Each cycle adv=1: encode u=0, out_valid <= 1, tail_cnt++.
    - When tail_cnt == K-2: this pair carries out_last=1, and state returns to DATA.
    - After the K-1 zero shifts, sr is all-zero, so no explicit clear is needed.
- Frame rules:
  - A frame produces N pairs when TAIL_EN=0, and N+K-1 pairs when TAIL_EN=1.
  - A single-bit frame (in_last on the first bit) is legal.
  - The next frame's first bit can be accepted the cycle after the last tail pair is loaded, provided adv=1. There are no idle bubbles beyond that.
- in_valid=0 in DATA: no advance, sr holds, and the frame stays open indefinitely.
- Reset mid-frame or mid-tail:
  - All state is cleared on the next edge and out_valid drops.
  - No partial tail is emitted.
  - The next accepted bit starts a fresh frame with sr=0.

Test Plan:
- Impulse, TAIL_EN=1: single bit 1 with in_last=1, out_ready=1 → pairs 11,10,11,11,00,01,11 on 7 consecutive cycles. out_last=1 only on the 7th; in_ready=0 during the 6 tail cycles.
- All-ones: 8 bits of 1, last on the 8th → first 7 pairs 11,01,10,01,01,00,11; 14 pairs total; final sr=0, checked by an immediate impulse frame reproducing the impulse pattern.
- Backpressure: during a 10-bit random frame, drop out_ready for 5 cycles mid-data and 3 cycles mid-tail → out_pair/out_last stable while stalled, in_ready=0. The pair sequence equals the no-stall golden model; 16 pairs total.
- Back-to-back frames: frame A = 3 bits (101), frame B = 2 bits (11), in_valid held high → out_last on pair 9 and pair 17. B's first pair is 11 (clean sr), with no gap cycles between A's last tail pair and B's first pair.
- TAIL_EN=0: frames 1 then 1 (two single-bit frames) → pairs 11 (out_last=1), 11 (out_last=1). There are no tail pairs, and in_ready stays 1 throughout.
- Reset mid-tail: rst=1 for 1 cycle during the 3rd tail pair → out_valid=0 the cycle after; the next single-bit frame of 1 reproduces the impulse response exactly. Also run loopback into the Viterbi decoder for 1000 random bits with zero bit errors.
